ec_point_add_double: RTL and testbench

Unified affine elliptic-curve point add/double unit over GF(p) with a start/done handshake. It handles every input class: point at infinity, P+Q, P+P and P+(−P). Its modular multiplier and inverter are sequential and internal, so the width N scales to 256+ without wide combinational `*` and `%`. It is the group-operation core that the scalar-multiplication controller drives.

---
 rtl/ec_point_add_double.sv | 206 ++++++++++++++++++++
 tb/tb_ec_point_add_double.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ec_point_add_double.sv
// Affine point add/double over GF(p) for short Weierstrass curves.
// A bit-serial multiplier and a binary inverter are shared across all steps.
module ec_point_add_double #(
    parameter int N = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] p,
    input  logic [N-1:0] a,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y1,
    input  logic         inf1,
    input  logic [N-1:0] x2,
    input  logic [N-1:0] y2,
    input  logic         inf2,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] x3,
    output logic [N-1:0] y3,
    output logic         inf3
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLASSIFY, S_SQ, S_SETUP, S_INV, S_MUL_L,
        S_MUL_L2, S_SUBX, S_MUL_Y, S_SUBY, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0] p_q, p_d, a_q, a_d;
    logic [N-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic         inf1_q, inf1_d, inf2_q, inf2_d, dbl_q, dbl_d;
    logic [N-1:0] t_q, t_d, lam_q, lam_d, xr_q, xr_d;
    logic [N-1:0] acc_q, acc_d, ma_q, ma_d, mb_q, mb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] u_q, u_d, v_q, v_d, g1_q, g1_d, g2_q, g2_d;
    logic [N-1:0] x3_q, x3_d, y3_q, y3_d;
    logic         inf3_q, inf3_d;

    function automatic logic [N-1:0] mod_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic [N-1:0] m);
        logic [N:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic [N-1:0] m);
        logic [N:0] s;
        if (x >= y) s = {1'b0, x} - {1'b0, y};
        else        s = {1'b0, x} + {1'b0, m} - {1'b0, y};
        return s[N-1:0];
    endfunction

    // x/2 mod m for odd m: add m first when x is odd so the shift is exact
    function automatic logic [N-1:0] mod_half(input logic [N-1:0] x, input logic [N-1:0] m);
        logic [N:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[N:1];
    endfunction

    logic [N-1:0] acc_dbl, mul_next, sub_x, den;
    logic         mul_last, accept;

    assign acc_dbl  = mod_add(acc_q, acc_q, p_q);
    assign mul_next = mb_q[N-1] ? mod_add(acc_dbl, ma_q, p_q) : acc_dbl;
    assign mul_last = (cnt_q == CW'(N - 1));
    assign sub_x    = mod_sub(mod_sub(acc_q, x1_q, p_q), x2_q, p_q);
    assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = (state_q == S_DONE);
    assign x3   = x3_q;
    assign y3   = y3_q;
    assign inf3 = inf3_q;

    always_comb begin
        state_d = state_q;
        p_d = p_q;   a_d = a_q;
        x1_d = x1_q; y1_d = y1_q; x2_d = x2_q; y2_d = y2_q;
        inf1_d = inf1_q; inf2_d = inf2_q; dbl_d = dbl_q;
        t_d = t_q; lam_d = lam_q; xr_d = xr_q;
        acc_d = acc_q; ma_d = ma_q; mb_d = mb_q; cnt_d = cnt_q;
        u_d = u_q; v_d = v_q; g1_d = g1_q; g2_d = g2_q;
        x3_d = x3_q; y3_d = y3_q; inf3_d = inf3_q;
        den = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    p_d = p;   a_d = a;
                    x1_d = x1; y1_d = y1; inf1_d = inf1;
                    x2_d = x2; y2_d = y2; inf2_d = inf2;
                    state_d = S_CLASSIFY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLASSIFY: begin
                if (inf1_q) begin
                    x3_d = inf2_q ? '0 : x2_q;
                    y3_d = inf2_q ? '0 : y2_q;
                    inf3_d = inf2_q;
                    state_d = S_DONE;
                end else if (inf2_q) begin
                    x3_d = x1_q; y3_d = y1_q; inf3_d = 1'b0;
                    state_d = S_DONE;
                end else if (x1_q == x2_q && (y1_q != y2_q || y1_q == '0)) begin
                    x3_d = '0; y3_d = '0; inf3_d = 1'b1;
                    state_d = S_DONE;
                end else if (x1_q == x2_q) begin
                    dbl_d = 1'b1;
                    ma_d = x1_q; mb_d = x1_q; acc_d = '0; cnt_d = '0;
                    state_d = S_SQ;
                end else begin
                    dbl_d = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SQ, S_MUL_L, S_MUL_L2, S_MUL_Y: begin
                acc_d = mul_next;
                mb_d  = mb_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (mul_last) begin
                    case (state_q)
                        S_SQ:     state_d = S_SETUP;
                        S_MUL_L: begin
                            // lam becomes both operands of the squaring that follows
                            lam_d = mul_next; ma_d = mul_next; mb_d = mul_next;
                            acc_d = '0; cnt_d = '0;
                            state_d = S_MUL_L2;
                        end
                        S_MUL_L2: state_d = S_SUBX;
                        default:  state_d = S_SUBY;
                    endcase
                end
            end
            S_SETUP: begin
                if (dbl_q) begin
                    t_d = mod_add(mod_add(mod_add(acc_q, acc_q, p_q), acc_q, p_q), a_q, p_q);
                    den = mod_add(y1_q, y1_q, p_q);
                end else begin
                    t_d = mod_sub(y2_q, y1_q, p_q);
                    den = mod_sub(x2_q, x1_q, p_q);
                end
                u_d = den; v_d = p_q; g1_d = ONE; g2_d = '0;
                state_d = S_INV;
            end
            S_INV: begin
                // invariants: g1*den == u, g2*den == v (mod p)
                if (u_q == ONE || v_q == ONE) begin
                    ma_d = t_q; mb_d = (u_q == ONE) ? g1_q : g2_q;
                    acc_d = '0; cnt_d = '0;
                    state_d = S_MUL_L;
                end else if (!u_q[0]) begin
                    u_d = u_q >> 1; g1_d = mod_half(g1_q, p_q);
                end else if (!v_q[0]) begin
                    v_d = v_q >> 1; g2_d = mod_half(g2_q, p_q);
                end else if (u_q >= v_q) begin
                    u_d = (u_q - v_q) >> 1; g1_d = mod_half(mod_sub(g1_q, g2_q, p_q), p_q);
                end else begin
                    v_d = (v_q - u_q) >> 1; g2_d = mod_half(mod_sub(g2_q, g1_q, p_q), p_q);
                end
            end
            S_SUBX: begin
                xr_d = sub_x;
                ma_d = lam_q; mb_d = mod_sub(x1_q, sub_x, p_q);
                acc_d = '0; cnt_d = '0;
                state_d = S_MUL_Y;
            end
            S_SUBY: begin
                x3_d = xr_q; y3_d = mod_sub(acc_q, y1_q, p_q); inf3_d = 1'b0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            p_q <= '0; a_q <= '0;
            x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
            inf1_q <= 1'b0; inf2_q <= 1'b0; dbl_q <= 1'b0;
            t_q <= '0; lam_q <= '0; xr_q <= '0;
            acc_q <= '0; ma_q <= '0; mb_q <= '0; cnt_q <= '0;
            u_q <= '0; v_q <= '0; g1_q <= '0; g2_q <= '0;
            x3_q <= '0; y3_q <= '0; inf3_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q <= p_d; a_q <= a_d;
            x1_q <= x1_d; y1_q <= y1_d; x2_q <= x2_d; y2_q <= y2_d;
            inf1_q <= inf1_d; inf2_q <= inf2_d; dbl_q <= dbl_d;
            t_q <= t_d; lam_q <= lam_d; xr_q <= xr_d;
            acc_q <= acc_d; ma_q <= ma_d; mb_q <= mb_d; cnt_q <= cnt_d;
            u_q <= u_d; v_q <= v_d; g1_q <= g1_d; g2_q <= g2_d;
            x3_q <= x3_d; y3_q <= y3_d; inf3_q <= inf3_d;
        end
    end

endmodule

// File: tb/tb_ec_point_add_double.sv
// Directed bench for ec_point_add_double on y^2 = x^3 + x + 1 over GF(23).
module tb_ec_point_add_double;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset, start, inf1, inf2;
    logic [N-1:0] p, a, x1, y1, x2, y2;
    logic         busy, done, inf3;
    logic [N-1:0] x3, y3;

    int n_checks = 0;
    int n_fail   = 0;
    int lat, tinv, done_seen;
    bit busy_ok, hold_ok;

    always #5 clk = ~clk;

    ec_point_add_double #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .p(p), .a(a),
        .x1(x1), .y1(y1), .inf1(inf1), .x2(x2), .y2(y2), .inf2(inf2),
        .busy(busy), .done(done), .x3(x3), .y3(y3), .inf3(inf3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts one operation and returns in its done cycle (#1 after the edge).
    task automatic run_op(input logic [N-1:0] ax1, input logic [N-1:0] ay1, input logic ai1,
                          input logic [N-1:0] ax2, input logic [N-1:0] ay2, input logic ai2,
                          input bit spam, output int olat, output bit obusy, output bit ohold);
        logic [N-1:0] px, py;
        logic         pi;
        px = x3; py = y3; pi = inf3;
        olat = -1; obusy = 1'b1; ohold = 1'b1;
        x1 = ax1; y1 = ay1; inf1 = ai1; x2 = ax2; y2 = ay2; inf2 = ai2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                olat = c;
                break;
            end
            if (busy !== 1'b1) obusy = 1'b0;
            if (x3 !== px || y3 !== py || inf3 !== pi) ohold = 1'b0;
            if (spam) begin
                start = 1'b1; x1 = 8'd1; y1 = 8'd2; inf1 = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        $display("op (%0d,%0d,%0d)+(%0d,%0d,%0d) -> (%0d,%0d) inf3=%0d latency=%0d",
                 ax1, ay1, ai1, ax2, ay2, ai2, x3, y3, inf3, olat);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; p = 8'd23; a = 8'd1;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; inf1 = 1'b0; inf2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x3", x3, 0);
        check("rst_y3", y3, 0);
        check("rst_inf3", inf3, 0);
        reset = 1'b0;
        idle_cycle();

        // Add (3,10)+(9,7): 6^-1 takes 5 inverter cycles
        run_op(3, 10, 0, 9, 7, 0, 0, lat, busy_ok, hold_ok);
        check("add_x3", x3, 17);
        check("add_y3", y3, 20);
        check("add_inf3", inf3, 0);
        check("add_busy_low_at_done", busy, 0);
        check("add_busy_whole_op", busy_ok, 1);
        check("add_hold", hold_ok, 1);
        check("add_latency", lat, 34);
        tinv = lat - 29;
        $display("add T_inv = %0d", tinv);
        check("add_tinv_bound", (tinv <= 18), 1);
        idle_cycle();
        check("done_one_cycle", done, 0);

        // Double (3,10): 20^-1 takes 6 inverter cycles, plus 8 for squaring
        run_op(3, 10, 0, 3, 10, 0, 0, lat, busy_ok, hold_ok);
        check("dbl_x3", x3, 7);
        check("dbl_y3", y3, 12);
        check("dbl_inf3", inf3, 0);
        check("dbl_latency", lat, 43);
        tinv = lat - 37;
        $display("double T_inv = %0d", tinv);
        check("dbl_tinv_bound", (tinv <= 18), 1);
        idle_cycle();

        run_op(3, 10, 0, 3, 13, 0, 0, lat, busy_ok, hold_ok);
        check("neg_inf3", inf3, 1);
        check("neg_x3", x3, 0);
        check("neg_y3", y3, 0);
        check("neg_latency", lat, 2);
        idle_cycle();

        run_op(0, 0, 1, 9, 7, 0, 0, lat, busy_ok, hold_ok);
        check("inf1_x3", x3, 9);
        check("inf1_y3", y3, 7);
        check("inf1_inf3", inf3, 0);
        check("inf1_latency", lat, 2);
        idle_cycle();

        run_op(5, 0, 0, 5, 0, 0, 0, lat, busy_ok, hold_ok);
        check("y0_inf3", inf3, 1);
        check("y0_x3", x3, 0);
        check("y0_latency", lat, 2);
        idle_cycle();

        run_op(3, 10, 0, 0, 0, 1, 0, lat, busy_ok, hold_ok);
        check("inf2_x3", x3, 3);
        check("inf2_y3", y3, 10);
        check("inf2_inf3", inf3, 0);
        idle_cycle();

        run_op(3, 10, 1, 9, 7, 1, 0, lat, busy_ok, hold_ok);
        check("both_inf3", inf3, 1);
        check("both_x3", x3, 0);
        check("both_y3", y3, 0);
        idle_cycle();

        // Repeated start while busy must be ignored
        run_op(3, 10, 0, 9, 7, 0, 1, lat, busy_ok, hold_ok);
        check("spam_x3", x3, 17);
        check("spam_y3", y3, 20);
        check("spam_latency", lat, 34);
        check("spam_hold", hold_ok, 1);

        // Accepted in the done cycle of the previous operation
        run_op(9, 7, 0, 17, 20, 0, 0, lat, busy_ok, hold_ok);
        check("b2b_x3", x3, 0);
        check("b2b_y3", y3, 22);
        check("b2b_inf3", inf3, 0);
        check("b2b_latency", lat, 33);
        idle_cycle();

        // Reset while the inverter is running
        x1 = 3; y1 = 10; inf1 = 0; x2 = 9; y2 = 7; inf2 = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycle();
        idle_cycle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_x3", x3, 0);
        check("midrst_y3", y3, 0);
        check("midrst_inf3", inf3, 0);
        done_seen = 0;
        for (int c = 0; c < 50; c++) begin
            if (done === 1'b1) done_seen++;
            idle_cycle();
        end
        check("midrst_no_done", done_seen, 0);

        run_op(3, 10, 0, 9, 7, 0, 0, lat, busy_ok, hold_ok);
        check("post_rst_x3", x3, 17);
        check("post_rst_y3", y3, 20);
        check("post_rst_latency", lat, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
